// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder producing one sum bit per clock, LSB first,
// from a full-adder slice built out of two half_adder cells and a registered carry.
module half_adder (
   input  logic i_a,
   input  logic i_b,
   output logic o_s,
   output logic o_c
);
   assign o_s = i_a ^ i_b;
   assign o_c = i_a & i_b;
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CIN,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] SUM,
   output logic             COUT
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;
   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic             r_c;
   logic [CW-1:0]    r_cnt;
   logic             w_s0;
   logic             w_c0;
   logic             w_s;
   logic             w_c1;
   logic             w_c_next;
   logic             w_last;
   logic [WIDTH-1:0] w_res_next;
   half_adder u_ha0 (.i_a(r_a[0]), .i_b(r_b[0]), .o_s(w_s0), .o_c(w_c0));
   half_adder u_ha1 (.i_a(w_s0),   .i_b(r_c),    .o_s(w_s),  .o_c(w_c1));
   assign w_c_next   = w_c0 | w_c1;
   assign w_last     = (r_cnt == CW'(WIDTH - 1));
   // New sum bit enters at the MSB so the LSB-first stream lands in order after WIDTH shifts
   assign w_res_next = WIDTH'({w_s, r_res} >> 1);
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_c     <= 1'b0;
         r_cnt   <= '0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
         SUM     <= '0;
         COUT    <= 1'b0;
      end else if (r_state == S_RUN) begin
         r_a   <= r_a >> 1;
         r_b   <= r_b >> 1;
         r_res <= w_res_next;
         r_c   <= w_c_next;
         r_cnt <= r_cnt + 1'b1;
         if (w_last) begin
            SUM     <= w_res_next;
            COUT    <= w_c_next;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
            r_state <= S_DONE;
         end
      end else if (START) begin
         r_a     <= A;
         r_b     <= B;
         r_c     <= CIN;
         r_cnt   <= '0;
         r_res   <= '0;
         BUSY    <= 1'b1;
         DONE    <= 1'b0;
         r_state <= S_RUN;
      end else begin
         DONE    <= 1'b0;
         r_state <= S_IDLE;
      end
   end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of the serial adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       cin = 1'b0;
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       cout;
   logic       st1 = 1'b0;
   logic       a1 = 1'b0;
   logic       b1 = 1'b0;
   logic       ci1 = 1'b0;
   logic       busy1;
   logic       done1;
   logic       sum1;
   logic       co1;
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut (
      .CLK(clk), .RESET_N(rst_n), .START(start), .A(a), .B(b), .CIN(cin),
      .BUSY(busy), .DONE(done), .SUM(sum), .COUT(cout)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .CLK(clk), .RESET_N(rst_n), .START(st1), .A(a1), .B(b1), .CIN(ci1),
      .BUSY(busy1), .DONE(done1), .SUM(sum1), .COUT(co1)
   );

   task automatic launch(input logic [7:0] va, input logic [7:0] vb, input logic vc);
      @(negedge clk);
      a = va;
      b = vb;
      cin = vc;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Steps negedge by negedge until DONE, counting cycles and BUSY samples along the way
   task automatic wait_done(output int n, output int nb);
      n = 0;
      nb = 0;
      do begin
         if (busy) nb++;
         @(negedge clk);
         n++;
      end while (!done && n < 40);
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, sum, cout} !== 11'd0) begin
         failures++;
         $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b want all 0", busy, done, sum, cout);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, done, busy1, done1} !== 4'd0) begin
         failures++;
         $display("FAIL reset_idle: got busy=%b done=%b busy1=%b done1=%b want 0", busy, done, busy1, done1);
      end
   endtask

   task automatic test_basic;
      int n, nb;
      launch(8'h3C, 8'h05, 1'b0);
      wait_done(n, nb);
      checks++;
      if (n !== 8) begin
         failures++;
         $display("FAIL basic_latency: got %0d cycles want 8", n);
      end
      checks++;
      if (nb !== 8) begin
         failures++;
         $display("FAIL basic_busy_cycles: got %0d want 8", nb);
      end
      checks++;
      if ({done, busy} !== 2'b10) begin
         failures++;
         $display("FAIL basic_done_busy: got done=%b busy=%b want 1/0", done, busy);
      end
      checks++;
      if ({cout, sum} !== 9'h041) begin
         failures++;
         $display("FAIL basic_sum: got cout=%b sum=%h want 0/41", cout, sum);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || sum !== 8'h41) begin
         failures++;
         $display("FAIL basic_done_pulse: got done=%b sum=%h want 0/41", done, sum);
      end
   endtask

   task automatic test_overflow;
      int n, nb;
      launch(8'hFF, 8'h01, 1'b0);
      wait_done(n, nb);
      checks++;
      if (done !== 1'b1 || {cout, sum} !== 9'h100) begin
         failures++;
         $display("FAIL overflow_ff_01: got done=%b cout=%b sum=%h want 1/1/00", done, cout, sum);
      end
      launch(8'hFF, 8'hFF, 1'b1);
      wait_done(n, nb);
      checks++;
      if (done !== 1'b1 || {cout, sum} !== 9'h1FF) begin
         failures++;
         $display("FAIL overflow_ff_ff_cin: got done=%b cout=%b sum=%h want 1/1/ff", done, cout, sum);
      end
   endtask

   task automatic test_start_ignored;
      int ndone = 0;
      logic [8:0] got = '0;
      launch(8'h10, 8'h20, 1'b0);
      repeat (2) @(negedge clk);
      a = 8'hAA;
      b = 8'h55;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) begin
            if (ndone == 0) got = {cout, sum};
            ndone++;
         end
      end
      checks++;
      if (ndone !== 1) begin
         failures++;
         $display("FAIL ignored_done_count: got %0d want 1", ndone);
      end
      checks++;
      if (got !== 9'h030) begin
         failures++;
         $display("FAIL ignored_result: got %h want 030", got);
      end
      checks++;
      if (sum !== 8'h30 || busy !== 1'b0) begin
         failures++;
         $display("FAIL ignored_hold: got sum=%h busy=%b want 30/0", sum, busy);
      end
   endtask

   task automatic test_back_to_back;
      int n, nb;
      @(negedge clk);
      a = 8'h01;
      b = 8'h02;
      cin = 1'b0;
      start = 1'b1;
      wait_done(n, nb);
      checks++;
      if (n !== 9 || {cout, sum} !== 9'h003) begin
         failures++;
         $display("FAIL b2b_first: got n=%0d cout=%b sum=%h want 9/0/03", n, cout, sum);
      end
      a = 8'h80;
      b = 8'h80;
      wait_done(n, nb);
      checks++;
      if (n !== 9 || done !== 1'b1) begin
         failures++;
         $display("FAIL b2b_spacing: got n=%0d done=%b want 9/1", n, done);
      end
      checks++;
      if (nb !== 8) begin
         failures++;
         $display("FAIL b2b_busy_cycles: got %0d want 8", nb);
      end
      checks++;
      if ({cout, sum} !== 9'h100) begin
         failures++;
         $display("FAIL b2b_second: got cout=%b sum=%h want 1/00", cout, sum);
      end
      start = 1'b0;
   endtask

   task automatic test_reset_mid;
      int n, nb;
      launch(8'h12, 8'h34, 1'b0);
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || {cout, sum} !== 9'h1FF) begin
         failures++;
         $display("FAIL midreset_pre: got busy=%b cout=%b sum=%h want 1/1/ff", busy, cout, sum);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, sum, cout} !== 11'd0) begin
         failures++;
         $display("FAIL midreset_async: got busy=%b done=%b sum=%h cout=%b want all 0", busy, done, sum, cout);
      end
      @(negedge clk);
      rst_n = 1'b1;
      launch(8'h07, 8'h09, 1'b0);
      wait_done(n, nb);
      checks++;
      if (n !== 8 || {cout, sum} !== 9'h010) begin
         failures++;
         $display("FAIL midreset_after: got n=%0d cout=%b sum=%h want 8/0/10", n, cout, sum);
      end
   endtask

   task automatic test_width1;
      logic [2:0] v;
      logic [1:0] exp;
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         exp = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
         @(negedge clk);
         a1 = v[2];
         b1 = v[1];
         ci1 = v[0];
         st1 = 1'b1;
         @(negedge clk);
         st1 = 1'b0;
         checks++;
         if (busy1 !== 1'b1 || done1 !== 1'b0) begin
            failures++;
            $display("FAIL w1_run_%0d: got busy=%b done=%b want 1/0", i, busy1, done1);
         end
         @(negedge clk);
         checks++;
         if (done1 !== 1'b1 || {co1, sum1} !== exp) begin
            failures++;
            $display("FAIL w1_sum_%0d: got done=%b result=%b want 1/%b", i, done1, {co1, sum1}, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_start_ignored();
      test_back_to_back();
      test_overflow();
      test_reset_mid();
      test_width1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
